// File: rtl/tms9918_pkg.sv
// Shared definitions for the TMS9918 host port: FSM encoding, VRAM width, control-byte flags.
package tms9918_pkg;

    localparam int VRAM_ADDR_W = 14;

    // Flag positions in the second control byte, MSB-first numbering.
    localparam int CTL_REG_BIT   = 0;
    localparam int CTL_WRITE_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEMRD = 2'd1,
        ST_MEMWR = 2'd2
    } cpuif_state_e;

endpackage

// File: rtl/tms9918_cpuif.sv
// TMS9918 CPU port: control/data byte decode, address latch, auto-increment VRAM pointer, read-ahead buffer.
// Results one cycle after the strobe; cpu_ready stays low from request issue through the mem_ack cycle.
module tms9918_cpuif
    import tms9918_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mode,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic [0:7]        cpu_wdata,
    output logic [0:7]        cpu_rdata,
    output logic              cpu_ready,
    output logic [0:2]        reg_addr,
    output logic [0:7]        reg_wdata,
    output logic              reg_wstrobe,
    input  logic [0:7]        reg_rdata,
    output logic              reg_rstrobe,
    output logic              mem_req,
    output logic              mem_we,
    output logic [0:ADDR_W-1] mem_addr,
    output logic [0:7]        mem_wdata,
    input  logic              mem_ack,
    input  logic [0:7]        mem_rdata
);

    localparam int HI_W = ADDR_W - 8;

    cpuif_state_e      state_q, state_d;
    logic [0:ADDR_W-1] addr_q, addr_d;
    logic              latched_q, latched_d;
    logic [0:7]        first_q, first_d;
    logic [0:7]        rbuf_q, rbuf_d;
    logic [0:7]        cpu_rdata_q, cpu_rdata_d;
    logic [0:2]        reg_addr_q, reg_addr_d;
    logic [0:7]        reg_wdata_q, reg_wdata_d;
    logic              reg_wstrobe_q, reg_wstrobe_d;
    logic              mem_we_q, mem_we_d;
    logic [0:ADDR_W-1] mem_addr_q, mem_addr_d;
    logic [0:7]        mem_wdata_q, mem_wdata_d;
    logic [0:ADDR_W-1] setup_addr;

    // Second address byte supplies the high bits; the low byte comes from the first byte already in addr.
    assign setup_addr = {cpu_wdata[8-HI_W:7], addr_q[ADDR_W-8:ADDR_W-1]};

    assign cpu_ready   = (state_q == ST_IDLE);
    assign mem_req     = (state_q != ST_IDLE);
    assign cpu_rdata   = cpu_rdata_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign reg_wstrobe = reg_wstrobe_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        latched_d     = latched_q;
        first_d       = first_q;
        rbuf_d        = rbuf_q;
        cpu_rdata_d   = cpu_rdata_q;
        reg_addr_d    = reg_addr_q;
        reg_wdata_d   = reg_wdata_q;
        reg_wstrobe_d = 1'b0;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        reg_rstrobe   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_wr) begin
                    if (cpu_mode) begin
                        if (!latched_q) begin
                            first_d                       = cpu_wdata;
                            addr_d[ADDR_W-8:ADDR_W-1]     = cpu_wdata;
                            latched_d                     = 1'b1;
                        end else begin
                            latched_d = 1'b0;
                            if (cpu_wdata[CTL_REG_BIT]) begin
                                reg_addr_d    = cpu_wdata[5:7];
                                reg_wdata_d   = first_q;
                                reg_wstrobe_d = 1'b1;
                            end else if (cpu_wdata[CTL_WRITE_BIT]) begin
                                addr_d = setup_addr;
                            end else begin
                                state_d    = ST_MEMRD;
                                mem_we_d   = 1'b0;
                                mem_addr_d = setup_addr;
                                addr_d     = setup_addr + ADDR_W'(1);
                            end
                        end
                    end else begin
                        state_d     = ST_MEMWR;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = cpu_wdata;
                        rbuf_d      = cpu_wdata;
                        addr_d      = addr_q + ADDR_W'(1);
                        latched_d   = 1'b0;
                    end
                end else if (cpu_rd) begin
                    latched_d = 1'b0;
                    if (cpu_mode) begin
                        cpu_rdata_d = reg_rdata;
                        reg_rstrobe = 1'b1;
                    end else begin
                        cpu_rdata_d = rbuf_q;
                        state_d     = ST_MEMRD;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = addr_q;
                        addr_d      = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_MEMRD: begin
                if (mem_ack) begin
                    rbuf_d  = mem_rdata;
                    state_d = ST_IDLE;
                end
            end
            ST_MEMWR: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            latched_q     <= 1'b0;
            first_q       <= '0;
            rbuf_q        <= '0;
            cpu_rdata_q   <= '0;
            reg_addr_q    <= '0;
            reg_wdata_q   <= '0;
            reg_wstrobe_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            latched_q     <= latched_d;
            first_q       <= first_d;
            rbuf_q        <= rbuf_d;
            cpu_rdata_q   <= cpu_rdata_d;
            reg_addr_q    <= reg_addr_d;
            reg_wdata_q   <= reg_wdata_d;
            reg_wstrobe_q <= reg_wstrobe_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_tms9918_cpuif.sv
// Scoreboard bench for tms9918_cpuif: byte-level reference model feeds expectation queues, a monitor compares.
module tb_tms9918_cpuif;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_mode = 1'b0, cpu_wr = 1'b0, cpu_rd = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [2:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wstrobe;
    logic [7:0]  reg_rdata = 8'h00;
    logic        reg_rstrobe;
    logic        mem_req, mem_we;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;

    tms9918_cpuif #(.ADDR_W(14)) dut (
        .clk(clk), .reset(reset),
        .cpu_mode(cpu_mode), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstrobe(reg_wstrobe),
        .reg_rdata(reg_rdata), .reg_rstrobe(reg_rstrobe),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  wdata;
    } mreq_t;

    int n_pass = 0, n_total = 0;

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model state and expectation queues
    logic [7:0]  vram_m [16384];
    logic [7:0]  mem_a  [16384];
    int          m_addr = 0;
    bit          m_latched = 1'b0;
    logic [7:0]  m_first = 8'h00;
    logic [7:0]  m_rbuf = 8'h00;
    mreq_t       mq[$];
    logic [10:0] rq[$];
    logic [7:0]  dq[$];
    bit          e_acc = 0, e_rd = 0, e_mem = 0, e_rs = 0;
    bit          mon_en = 0;

    // Arbiter model
    int arb_fixed = -1;
    int arb_cnt = 0;
    bit arb_busy = 0;
    bit stray_req = 0;

    always begin
        @(posedge clk);
        #2;
        if (mem_ack) begin
            mem_ack  = 1'b0;
            arb_busy = 1'b0;
        end else if (mem_req) begin
            if (!arb_busy) begin
                arb_busy = 1'b1;
                arb_cnt  = (arb_fixed >= 0) ? arb_fixed : int'($urandom_range(0, 3));
            end
            if (arb_cnt == 0) begin
                mem_ack = 1'b1;
                if (mem_we) mem_a[mem_addr] = mem_wdata;
                else        mem_rdata = mem_a[mem_addr];
            end else begin
                arb_cnt--;
            end
        end else begin
            arb_busy = 1'b0;
            if (stray_req) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'h5A;
                stray_req = 1'b0;
            end
        end
    end

    // Monitor
    bit    req_prev = 0, rd_pend = 0, pend_mem = 0;
    mreq_t cur;
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_req && !req_prev) begin
                if (mq.size() == 0) check("mem_req_unexpected", 1, 0);
                else begin
                    cur = mq.pop_front();
                    check("mem_we", mem_we, cur.we);
                    check("mem_addr", mem_addr, cur.addr);
                    if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                end
            end else if (mem_req) begin
                check("mem_addr_stable", mem_addr, cur.addr);
                check("mem_we_stable", mem_we, cur.we);
                if (cur.we) check("mem_wdata_stable", mem_wdata, cur.wdata);
            end
            req_prev = mem_req;

            if (reg_wstrobe) begin
                if (rq.size() == 0) check("reg_wstrobe_unexpected", 1, 0);
                else begin
                    logic [10:0] e;
                    e = rq.pop_front();
                    check("reg_addr", reg_addr, e[10:8]);
                    check("reg_wdata", reg_wdata, e[7:0]);
                end
            end

            if (rd_pend) begin
                rd_pend = 0;
                if (dq.size() == 0) check("rdata_unexpected", 1, 0);
                else check("cpu_rdata", cpu_rdata, dq.pop_front());
            end

            check("cpu_ready", cpu_ready, !pend_mem);
            check("reg_rstrobe", reg_rstrobe, e_rs);

            if (cpu_wr || cpu_rd) begin
                check("accept", cpu_ready, e_acc);
                if (e_acc && e_rd)  rd_pend = 1;
                if (e_acc && e_mem) pend_mem = 1;
            end
            if ((mem_ack && mem_req) || reset) pend_mem = 0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!cpu_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!cpu_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic prefetch();
        mq.push_back('{1'b0, 14'(m_addr), 8'h00});
        m_rbuf = vram_m[m_addr];
        m_addr = (m_addr + 1) % 16384;
        e_mem  = 1;
    endtask

    task automatic access(bit mode, bit wr, bit rd, logic [7:0] b);
        wait_ready();
        reg_rdata = 8'($urandom);
        e_acc = 1; e_rd = 0; e_mem = 0; e_rs = 0;
        if (wr) begin
            if (mode) begin
                if (!m_latched) begin
                    m_first   = b;
                    m_addr    = (m_addr & 'h3F00) | int'(b);
                    m_latched = 1;
                end else begin
                    m_latched = 0;
                    if (b[7]) rq.push_back({b[2:0], m_first});
                    else begin
                        m_addr = ((int'(b) & 'h3F) << 8) | (m_addr & 'hFF);
                        if (!b[6]) prefetch();
                    end
                end
            end else begin
                mq.push_back('{1'b1, 14'(m_addr), b});
                vram_m[m_addr] = b;
                m_rbuf    = b;
                m_addr    = (m_addr + 1) % 16384;
                m_latched = 0;
                e_mem     = 1;
            end
        end else if (rd) begin
            e_rd = 1;
            m_latched = 0;
            if (mode) begin
                dq.push_back(reg_rdata);
                e_rs = 1;
            end else begin
                dq.push_back(m_rbuf);
                prefetch();
            end
        end
        cpu_mode = mode; cpu_wr = wr; cpu_rd = rd; cpu_wdata = b;
        @(posedge clk); #1;
        cpu_wr = 0; cpu_rd = 0;
        e_acc = 0; e_rd = 0; e_mem = 0; e_rs = 0;
    endtask

    // Strobe issued while busy: the model does not change
    task automatic ignored(bit mode, bit wr, bit rd, logic [7:0] b);
        e_acc = 0; e_rd = 0; e_mem = 0; e_rs = 0;
        cpu_mode = mode; cpu_wr = wr; cpu_rd = rd; cpu_wdata = b;
        @(posedge clk); #1;
        cpu_wr = 0; cpu_rd = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            vram_m[i] = v;
            mem_a[i]  = v;
        end
        vram_m[14'h1234] = 8'hAA; mem_a[14'h1234] = 8'hAA;
        vram_m[14'h1235] = 8'hBB; mem_a[14'h1235] = 8'hBB;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_rdata", cpu_rdata, 8'h00);
        check("rst_cpu_ready", cpu_ready, 1);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        check("rst_reg_wstrobe", reg_wstrobe, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1;

        // Register write
        access(1, 1, 0, 8'hE2);
        access(1, 1, 0, 8'h81);
        // Read setup at 1234 and two reads
        access(1, 1, 0, 8'h34);
        access(1, 1, 0, 8'h12);
        access(0, 0, 1, 8'h00);
        access(0, 0, 1, 8'h00);
        // Write setup at 3FFF, writes wrap to 0000, read returns last written byte
        access(1, 1, 0, 8'hFF);
        access(1, 1, 0, 8'h7F);
        access(0, 1, 0, 8'h11);
        access(0, 1, 0, 8'h22);
        access(0, 0, 1, 8'h00);
        // Status read clears the latch
        access(1, 1, 0, 8'h55);
        access(1, 0, 1, 8'h00);
        access(1, 1, 0, 8'h66);
        access(1, 1, 0, 8'h01);
        access(0, 0, 1, 8'h00);
        access(0, 0, 1, 8'h00);
        // Busy drop
        arb_fixed = 5;
        access(0, 0, 1, 8'h00);
        ignored(0, 1, 0, 8'h77);
        ignored(1, 1, 0, 8'h33);
        ignored(1, 0, 1, 8'h00);
        arb_fixed = -1;
        access(0, 0, 1, 8'h00);
        access(0, 1, 1, 8'h5C);
        access(0, 0, 1, 8'h00);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: access(1, 1, 0, 8'($urandom));
                3:       access(1, 0, 1, 8'h00);
                4, 5, 6: access(0, 1, 0, 8'($urandom));
                7, 8:    access(0, 0, 1, 8'h00);
                default: access(r[0], 1, 1, 8'($urandom));
            endcase
        end

        // Reset in the middle of a prefetch
        wait_ready();
        arb_fixed = 10;
        access(0, 0, 1, 8'h00);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", mem_req, 0);
        check("midrst_cpu_ready", cpu_ready, 1);
        m_addr = 0; m_latched = 0; m_rbuf = 8'h00;
        arb_fixed = -1;
        @(posedge clk); #1;
        stray_req = 1;
        repeat (3) @(posedge clk);
        #1;
        access(0, 0, 1, 8'h00);
        access(0, 0, 1, 8'h00);

        begin
            int n = 0;
            while ((mq.size() != 0 || rq.size() != 0 || dq.size() != 0 || !cpu_ready) && n < 200) begin
                @(posedge clk); #1; n++;
            end
        end
        @(negedge clk);
        check("drain_mem_q", mq.size(), 0);
        check("drain_reg_q", rq.size(), 0);
        check("drain_rd_q", dq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
